// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide with HI/LO registers, one bit per cycle.
// Define MULDIV_SIGNED_EN to make op 2/3 (MULT/DIV) signed; otherwise they run as MULTU/DIVU.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state, w_state_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_m;
  logic             r_is_div, r_b_zero, r_done, r_dbz;
  logic [WIDTH-1:0] r_hi, r_lo;

  logic             w_issue, w_last, w_mthi, w_mtlo;
  logic [WIDTH-1:0] w_a_mag, w_b_mag;
  logic [WIDTH:0]   w_mul_sum, w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;
  logic [WIDTH-1:0] w_acc_next, w_q_next;
  logic [WIDTH-1:0] w_hi_res, w_lo_res;

  assign w_issue = (r_state == S_IDLE) && start && !op[2];
  assign w_mthi  = (r_state == S_IDLE) && start && (op == 3'd4);
  assign w_mtlo  = (r_state == S_IDLE) && start && (op == 3'd5);
  assign w_last  = (r_state == S_RUN) && (r_cnt == CW'(1));

`ifdef MULDIV_SIGNED_EN
  logic             r_neg_q, r_neg_r;
  logic [WIDTH-1:0] w_a_neg, w_b_neg;
  logic [2*WIDTH-1:0] w_prod_neg;
  assign w_a_neg = -a;
  assign w_b_neg = -b;
  assign w_a_mag = (op[1] && a[WIDTH-1]) ? w_a_neg : a;
  assign w_b_mag = (op[1] && b[WIDTH-1]) ? w_b_neg : b;
  assign w_prod_neg = -{w_acc_next, w_q_next};
  // Multiply negates the full double-width product; divide fixes quotient and remainder separately.
  always_comb begin
    w_hi_res = w_acc_next;
    w_lo_res = w_q_next;
    if (r_is_div) begin
      if (r_neg_r) w_hi_res = -w_acc_next;
      if (r_neg_q) w_lo_res = -w_q_next;
    end else if (r_neg_q) begin
      w_hi_res = w_prod_neg[2*WIDTH-1:WIDTH];
      w_lo_res = w_prod_neg[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_issue) begin
      r_neg_q <= op[1] && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r <= op[1] && op[0] && a[WIDTH-1];
    end
  end
`else
  assign w_a_mag  = a;
  assign w_b_mag  = b;
  assign w_hi_res = w_acc_next;
  assign w_lo_res = w_q_next;
`endif

  // Multiply: {acc,q} shifts right with the partial sum; divide: {acc,q} shifts left, quotient bits enter q.
  assign w_mul_sum = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
  assign w_shift   = {r_acc, r_q[WIDTH-1]};
  assign w_ge      = w_shift >= {1'b0, r_m};
  assign w_diff    = w_shift[WIDTH-1:0] - r_m;

  always_comb begin
    w_acc_next = w_mul_sum[WIDTH:1];
    w_q_next   = {w_mul_sum[0], r_q[WIDTH-1:1]};
    if (r_is_div) begin
      w_acc_next = w_ge ? w_diff : w_shift[WIDTH-1:0];
      w_q_next   = {r_q[WIDTH-2:0], w_ge};
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_issue) w_state_next = S_RUN;
      S_RUN:   if (w_last)  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_acc    <= '0;
      r_q      <= '0;
      r_m      <= '0;
      r_is_div <= 1'b0;
      r_b_zero <= 1'b0;
      r_done   <= 1'b0;
      r_dbz    <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
    end else begin
      r_done <= w_last;
      r_dbz  <= w_last && r_is_div && r_b_zero;
      if (w_issue) begin
        r_cnt    <= CW'(WIDTH);
        r_acc    <= '0;
        r_is_div <= op[0];
        r_b_zero <= (b == '0);
        r_q      <= op[0] ? w_a_mag : w_b_mag;
        r_m      <= op[0] ? w_b_mag : w_a_mag;
      end else if (r_state == S_RUN) begin
        r_cnt <= r_cnt - CW'(1);
        r_acc <= w_acc_next;
        r_q   <= w_q_next;
        if (w_last) begin
          r_hi <= w_hi_res;
          r_lo <= w_lo_res;
        end
      end
      if (w_mthi) r_hi <= a;
      if (w_mtlo) r_lo <= a;
    end
  end

  assign busy        = (r_state == S_RUN);
  assign done        = r_done;
  assign div_by_zero = r_dbz;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed self-checking bench for muldiv_unit: multiply, divide, divide-by-zero, MTHI/MTLO,
// start-while-busy rejection and asynchronous reset abort.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, done, div_by_zero;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  int ncyc;
  bit seen_done;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] av, input logic [31:0] bv);
    start = 1'b1; op = o; a = av; b = bv;
    tick();
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen, capped at 100.
  task automatic wait_done(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!done && n < 100);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0;
    #2 rst_n = 1'b0;
    tick(); tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dbz",  {31'd0, div_by_zero}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    rst_n = 1'b1;
    tick();

    // 1: MULTU max*max
    issue(3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("t1_busy_e0", {31'd0, busy}, 32'd1);
    wait_done(ncyc);
    $display("MULTU ffffffff*ffffffff cycles=%0d hi=%h lo=%h", ncyc, hi, lo);
    check("t1_latency", ncyc, 32'd32);
    check("t1_busy_done", {31'd0, busy}, 32'd0);
    check("t1_hi", hi, 32'hFFFF_FFFE);
    check("t1_lo", lo, 32'h0000_0001);
    tick();
    check("t1_done_pulse", {31'd0, done}, 32'd0);

    // 2: DIVU 100/7, then MULTU 3*5 issued in the done cycle
    issue(3'd1, 32'd100, 32'd7);
    wait_done(ncyc);
    $display("DIVU 100/7 cycles=%0d hi=%h lo=%h", ncyc, hi, lo);
    check("t2_latency", ncyc, 32'd32);
    check("t2_lo", lo, 32'd14);
    check("t2_hi", hi, 32'd2);
    check("t2_dbz", {31'd0, div_by_zero}, 32'd0);
    issue(3'd0, 32'd3, 32'd5);
    check("t2b_busy", {31'd0, busy}, 32'd1);
    wait_done(ncyc);
    $display("MULTU 3*5 back-to-back cycles=%0d hi=%h lo=%h", ncyc, hi, lo);
    check("t2b_latency", ncyc, 32'd32);
    check("t2b_hi", hi, 32'd0);
    check("t2b_lo", lo, 32'd15);

    // 3: signed ops (expectations depend on the build)
    issue(3'd3, 32'hFFFF_FFF9, 32'd2);
    wait_done(ncyc);
    $display("DIV fffffff9/2 hi=%h lo=%h", hi, lo);
`ifdef MULDIV_SIGNED_EN
    check("t3_lo", lo, 32'hFFFF_FFFD);
    check("t3_hi", hi, 32'hFFFF_FFFF);
`else
    check("t3_lo", lo, 32'h7FFF_FFFC);
    check("t3_hi", hi, 32'h0000_0001);
`endif
    issue(3'd3, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(ncyc);
    $display("DIV 80000000/ffffffff hi=%h lo=%h", hi, lo);
`ifdef MULDIV_SIGNED_EN
    check("t3b_lo", lo, 32'h8000_0000);
    check("t3b_hi", hi, 32'h0000_0000);
`else
    check("t3b_lo", lo, 32'h0000_0000);
    check("t3b_hi", hi, 32'h8000_0000);
`endif
    issue(3'd2, 32'hFFFF_FFFD, 32'd5);
    wait_done(ncyc);
    $display("MULT fffffffd*5 hi=%h lo=%h", hi, lo);
`ifdef MULDIV_SIGNED_EN
    check("t3c_hi", hi, 32'hFFFF_FFFF);
`else
    check("t3c_hi", hi, 32'h0000_0004);
`endif
    check("t3c_lo", lo, 32'hFFFF_FFF1);

    // 4: DIVU by zero
    issue(3'd1, 32'd5, 32'd0);
    check("t4_dbz_early", {31'd0, div_by_zero}, 32'd0);
    wait_done(ncyc);
    $display("DIVU 5/0 cycles=%0d hi=%h lo=%h dbz=%0d", ncyc, hi, lo, div_by_zero);
    check("t4_latency", ncyc, 32'd32);
    check("t4_dbz", {31'd0, div_by_zero}, 32'd1);
    check("t4_lo", lo, 32'hFFFF_FFFF);
    check("t4_hi", hi, 32'd5);
    tick();
    check("t4_dbz_pulse", {31'd0, div_by_zero}, 32'd0);

    // 5: MTLO while idle, then MTHI/DIVU attempts while busy
    issue(3'd5, 32'h0000_1234, 32'd0);
    $display("MTLO 1234 hi=%h lo=%h busy=%0d", hi, lo, busy);
    check("t5_lo", lo, 32'h0000_1234);
    check("t5_hi_kept", hi, 32'd5);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_done", {31'd0, done}, 32'd0);
    issue(3'd0, 32'd6, 32'd7);
    issue(3'd4, 32'h0000_DEAD, 32'd0);
    issue(3'd1, 32'd1000, 32'd3);
    check("t5_hi_hold", hi, 32'd5);
    check("t5_lo_hold", lo, 32'h0000_1234);
    wait_done(ncyc);
    $display("MULTU 6*7 with ignored starts cycles=%0d hi=%h lo=%h", ncyc, hi, lo);
    check("t5_latency", ncyc, 32'd30);
    check("t5_mul_hi", hi, 32'd0);
    check("t5_mul_lo", lo, 32'd42);
    tick();

    // 6: asynchronous reset in the middle of MULTU 7*9
    issue(3'd0, 32'd7, 32'd9);
    for (int i = 0; i < 9; i++) tick();
    rst_n = 1'b0;
    #1;
    $display("reset mid-MULTU busy=%0d hi=%h lo=%h", busy, hi, lo);
    check("t6_busy", {31'd0, busy}, 32'd0);
    check("t6_hi", hi, 32'd0);
    check("t6_lo", lo, 32'd0);
    tick();
    rst_n = 1'b1;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen_done = 1'b1;
    end
    check("t6_no_done", {31'd0, seen_done}, 32'd0);
    check("t6_lo_after", lo, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
